seq_alu_unit: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle ArithmeticLogicUnit.
- Accepts one operation per Start pulse and runs a small FSM.
- Shift/rotate ops execute iteratively by a variable amount, one bit position per cycle.
- Results and the Z/C/N/O flag register are updated on completion; it feeds the datapath in place of the fixed single-bit-shift ALU.

---
 rtl/seq_alu_unit.sv | 278 +++++++++++++++++++++++++++
 tb/tb_seq_alu_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seq_alu_unit.sv
// Multi-cycle ALU: one operation per Start, shifts/rotates iterate one bit per cycle.
// Result and {Z,C,N,O} flags are registered and updated together with the Done pulse.
module seq_alu_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [4:0]       FunSel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   ShAmt,
  input  logic             WF,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut
);

  localparam int HALF = WIDTH / 2;
  localparam logic [WIDTH-1:0] LO_MASK = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};

  localparam logic [3:0] OP_A    = 4'd0;
  localparam logic [3:0] OP_B    = 4'd1;
  localparam logic [3:0] OP_NA   = 4'd2;
  localparam logic [3:0] OP_NB   = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_ADC  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NAND = 4'd10;
  localparam logic [3:0] OP_LSL  = 4'd11;
  localparam logic [3:0] OP_LSR  = 4'd12;
  localparam logic [3:0] OP_ASR  = 4'd13;
  localparam logic [3:0] OP_CSL  = 4'd14;
  localparam logic [3:0] OP_CSR  = 4'd15;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             full_q, full_d;
  logic             wf_q, wf_d;
  logic             cin_q, cin_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic [3:0]       flags_q, flags_d;

  logic             start_is_shift;
  logic             run_is_shift;
  logic [WIDTH-1:0] sh_full;
  logic             sh_full_out;
  logic [HALF-1:0]  sh_half;
  logic             sh_half_out;
  logic [WIDTH-1:0] sh_val;
  logic             sh_out;
  logic [WIDTH-1:0] opb;
  logic             cin_add;
  logic [WIDTH:0]   sum_full;
  logic [HALF:0]    sum_half;
  logic [WIDTH-1:0] res_raw;
  logic [WIDTH-1:0] res;
  logic             res_z;
  logic             res_msb;
  logic             arith_c;
  logic             a_sign;
  logic             b_sign;
  logic             arith_o;
  logic [3:0]       flags_new;

  assign start_is_shift = (FunSel[3:0] >= OP_LSL);
  assign run_is_shift   = (op_q >= OP_LSL);

  // One-bit shift/rotate step over the full width.
  always_comb begin
    sh_full     = a_q;
    sh_full_out = 1'b0;
    case (op_q)
      OP_LSL: begin
        sh_full     = {a_q[WIDTH-2:0], 1'b0};
        sh_full_out = a_q[WIDTH-1];
      end
      OP_LSR: begin
        sh_full     = {1'b0, a_q[WIDTH-1:1]};
        sh_full_out = a_q[0];
      end
      OP_ASR: begin
        sh_full     = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        sh_full_out = a_q[0];
      end
      OP_CSL: begin
        sh_full     = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
        sh_full_out = a_q[WIDTH-1];
      end
      OP_CSR: begin
        sh_full     = {a_q[0], a_q[WIDTH-1:1]};
        sh_full_out = a_q[0];
      end
      default: begin
        sh_full     = a_q;
        sh_full_out = 1'b0;
      end
    endcase
  end

  // Same step confined to the low HALF bits; the sign for ASR is bit HALF-1.
  always_comb begin
    sh_half     = a_q[HALF-1:0];
    sh_half_out = 1'b0;
    case (op_q)
      OP_LSL: begin
        sh_half     = {a_q[HALF-2:0], 1'b0};
        sh_half_out = a_q[HALF-1];
      end
      OP_LSR: begin
        sh_half     = {1'b0, a_q[HALF-1:1]};
        sh_half_out = a_q[0];
      end
      OP_ASR: begin
        sh_half     = {a_q[HALF-1], a_q[HALF-1:1]};
        sh_half_out = a_q[0];
      end
      OP_CSL: begin
        sh_half     = {a_q[HALF-2:0], a_q[HALF-1]};
        sh_half_out = a_q[HALF-1];
      end
      OP_CSR: begin
        sh_half     = {a_q[0], a_q[HALF-1:1]};
        sh_half_out = a_q[0];
      end
      default: begin
        sh_half     = a_q[HALF-1:0];
        sh_half_out = 1'b0;
      end
    endcase
  end

  assign sh_val = full_q ? sh_full : {{(WIDTH-HALF){1'b0}}, sh_half};
  assign sh_out = full_q ? sh_full_out : sh_half_out;

  // Adder shared by ADD/ADC/SUB; SUB is A + ~B + 1.
  assign opb     = (op_q == OP_SUB) ? ~b_q : b_q;
  assign cin_add = (op_q == OP_SUB) ? 1'b1 : ((op_q == OP_ADC) ? cin_q : 1'b0);
  assign sum_full = {1'b0, a_q} + {1'b0, opb} + {{WIDTH{1'b0}}, cin_add};
  assign sum_half = {1'b0, a_q[HALF-1:0]} + {1'b0, opb[HALF-1:0]} + {{HALF{1'b0}}, cin_add};

  always_comb begin
    res_raw = a_q;
    case (op_q)
      OP_A:    res_raw = a_q;
      OP_B:    res_raw = b_q;
      OP_NA:   res_raw = ~a_q;
      OP_NB:   res_raw = ~b_q;
      OP_ADD,
      OP_ADC,
      OP_SUB:  res_raw = full_q ? sum_full[WIDTH-1:0]
                                : {{(WIDTH-HALF){1'b0}}, sum_half[HALF-1:0]};
      OP_AND:  res_raw = a_q & b_q;
      OP_OR:   res_raw = a_q | b_q;
      OP_XOR:  res_raw = a_q ^ b_q;
      OP_NAND: res_raw = ~(a_q & b_q);
      default: res_raw = sh_val;
    endcase
  end

  assign res     = full_q ? res_raw : (res_raw & LO_MASK);
  assign res_z   = (res == '0);
  assign res_msb = full_q ? res[WIDTH-1] : res[HALF-1];
  assign arith_c = full_q ? sum_full[WIDTH] : sum_half[HALF];
  assign a_sign  = full_q ? a_q[WIDTH-1] : a_q[HALF-1];
  assign b_sign  = full_q ? opb[WIDTH-1] : opb[HALF-1];
  assign arith_o = (a_sign == b_sign) && (res_msb != a_sign);

  // Flag layout is {Z,C,N,O}; untouched bits keep their previous value.
  always_comb begin
    flags_new = flags_q;
    case (op_q)
      OP_ADD, OP_ADC, OP_SUB: flags_new = {res_z, arith_c, res_msb, arith_o};
      OP_LSL, OP_LSR, OP_CSL, OP_CSR: begin
        flags_new[3] = res_z;
        flags_new[2] = sh_out;
        flags_new[1] = res_msb;
      end
      OP_ASR: begin
        flags_new[3] = res_z;
        flags_new[2] = sh_out;
      end
      default: begin
        flags_new[3] = res_z;
        flags_new[1] = res_msb;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    full_d  = full_q;
    wf_d    = wf_q;
    cin_d   = cin_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    alu_d   = alu_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          op_d    = FunSel[3:0];
          full_d  = FunSel[4];
          wf_d    = WF;
          cin_d   = flags_q[2];
          cnt_d   = (start_is_shift && (ShAmt != '0)) ? ShAmt : SHW'(1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (run_is_shift) begin
          a_d = sh_val;
        end
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          alu_d   = res;
          flags_d = wf_q ? flags_new : flags_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      full_q  <= 1'b0;
      wf_q    <= 1'b0;
      cin_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      alu_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      full_q  <= full_d;
      wf_q    <= wf_d;
      cin_q   <= cin_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      alu_q   <= alu_d;
      flags_q <= flags_d;
    end
  end

  assign Busy     = (state_q == S_RUN);
  assign Done     = done_q;
  assign ALUOut   = alu_q;
  assign FlagsOut = flags_q;

endmodule

// File: tb/tb_seq_alu_unit.sv
// Directed bench for seq_alu_unit: hand-computed results, flags and latencies.
module tb_seq_alu_unit;
  localparam int W   = 16;
  localparam int SHW = 4;

  logic           Clock = 1'b0;
  logic           Reset;
  logic           Start;
  logic [4:0]     FunSel;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [SHW-1:0] ShAmt;
  logic           WF;
  logic           Busy;
  logic           Done;
  logic [W-1:0]   ALUOut;
  logic [3:0]     FlagsOut;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;

  always #5 Clock = ~Clock;

  seq_alu_unit #(.WIDTH(W), .SHW(SHW)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .FunSel(FunSel),
    .A(A), .B(B), .ShAmt(ShAmt), .WF(WF),
    .Busy(Busy), .Done(Done), .ALUOut(ALUOut), .FlagsOut(FlagsOut)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the inputs after the Start edge, wait for Done.
  task automatic do_op(input string tag, input logic [4:0] fs, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [SHW-1:0] sh, input logic wf,
                       input int exp_lat, input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
    int n;
    @(negedge Clock);
    FunSel = fs; A = a; B = b; ShAmt = sh; WF = wf; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0; A = ~a; B = ~b; ShAmt = sh + 1'b1; WF = ~wf;
    n = 1;
    while (Done !== 1'b1 && n < 40) begin
      @(negedge Clock);
      n++;
    end
    $display("%s: fs=%b a=%h b=%h sh=%0d wf=%b -> out=%h flags=%b latency=%0d",
             tag, fs, a, b, sh, wf, ALUOut, FlagsOut, n);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"}, ALUOut, exp_res);
    check({tag, "_flags"}, FlagsOut, exp_flags);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; FunSel = '0; A = '0; B = '0; ShAmt = '0; WF = 1'b0;
    repeat (2) @(negedge Clock);
    $display("reset: busy=%b done=%b out=%h flags=%b", Busy, Done, ALUOut, FlagsOut);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_out", ALUOut, 16'h0000);
    check("rst_flags", FlagsOut, 4'b0000);
    Reset = 1'b0;

    // FFFF+1 = 0 carry out, no overflow -> flags 1100
    do_op("set_1100", 5'b10100, 16'hFFFF, 16'h0001, 4'd0, 1'b1, 2, 16'h0000, 4'b1100);
    // AA+CC = 176: low byte 76, carry 1; two negatives giving positive -> O=1
    do_op("narrow_add", 5'b00100, 16'h00AA, 16'h00CC, 4'd0, 1'b1, 2, 16'h0076, 4'b0101);
    @(negedge Clock);
    check("done_single_pulse", Done, 1'b0);

    // 4000+4000 = 8000 -> Z0 C0 N1 O1
    do_op("set_0011", 5'b10100, 16'h4000, 16'h4000, 4'd0, 1'b1, 2, 16'h8000, 4'b0011);
    do_op("asr3", 5'b11101, 16'h8001, 16'h0000, 4'd3, 1'b1, 4, 16'hF000, 4'b0011);
    do_op("asr0", 5'b11101, 16'h8001, 16'h0000, 4'd0, 1'b1, 2, 16'hC000, 4'b0111);

    do_op("set_0011b", 5'b10100, 16'h4000, 16'h4000, 4'd0, 1'b1, 2, 16'h8000, 4'b0011);
    do_op("pass_a_wf1", 5'b10000, 16'h0000, 16'h0000, 4'd0, 1'b1, 2, 16'h0000, 4'b1001);
    do_op("set_0011c", 5'b10100, 16'h4000, 16'h4000, 4'd0, 1'b1, 2, 16'h8000, 4'b0011);
    do_op("pass_a_wf0", 5'b10000, 16'h0000, 16'h0000, 4'd0, 1'b0, 2, 16'h0000, 4'b0011);

    do_op("set_c1", 5'b10100, 16'hFFFF, 16'h0001, 4'd0, 1'b1, 2, 16'h0000, 4'b1100);
    do_op("adc", 5'b10101, 16'h0001, 16'h0002, 4'd0, 1'b1, 2, 16'h0004, 4'b0000);

    // Handshake: 5-step CSL of F800 -> 001F, last bit out 1
    @(negedge Clock);
    FunSel = 5'b11110; A = 16'hF800; B = 16'h0000; ShAmt = 4'd5; WF = 1'b1; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0; lat = 1;
    @(negedge Clock);
    lat = 2;
    check("hs_busy", Busy, 1'b1);
    FunSel = 5'b10000; A = 16'h5555; Start = 1'b1;
    @(negedge Clock);
    lat = 3; Start = 1'b0;
    while (Done !== 1'b1 && lat < 40) begin
      @(negedge Clock);
      lat++;
    end
    $display("csl5: out=%h flags=%b latency=%0d", ALUOut, FlagsOut, lat);
    check("hs_csl_latency", lat, 6);
    check("hs_csl_result", ALUOut, 16'h001F);
    check("hs_csl_flags", FlagsOut, 4'b0100);
    FunSel = 5'b10001; A = 16'h0000; B = 16'h1234; WF = 1'b1; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    check("hs_back_done_low", Done, 1'b0);
    check("hs_back_busy", Busy, 1'b1);
    @(negedge Clock);
    $display("pass_b after done: out=%h flags=%b done=%b", ALUOut, FlagsOut, Done);
    check("hs_back_done", Done, 1'b1);
    check("hs_back_result", ALUOut, 16'h1234);
    check("hs_back_flags", FlagsOut, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("hs_no_queued_done", Done, 1'b0);
      check("hs_idle", Busy, 1'b0);
    end
    check("hs_out_kept", ALUOut, 16'h1234);

    // 8000 - 1 = 7FFF, carry 1, overflow 1
    do_op("sub", 5'b10110, 16'h8000, 16'h0001, 4'd0, 1'b1, 2, 16'h7FFF, 4'b0101);
    // Narrow LSR by 3 of 96: 4B(c0) 25(c1) 12(c1); upper byte ignored
    do_op("narrow_lsr3", 5'b01100, 16'hFF96, 16'h0000, 4'd3, 1'b1, 4, 16'h0012, 4'b0101);
    // Narrow ASR replicates bit 7: 80 -> C0 -> E0; N,O kept
    do_op("narrow_asr2", 5'b01101, 16'h0080, 16'h0000, 4'd2, 1'b1, 3, 16'h00E0, 4'b0001);

    // Reset in the middle of a 7-step LSR
    @(negedge Clock);
    FunSel = 5'b11100; A = 16'hFFFF; B = 16'h0000; ShAmt = 4'd7; WF = 1'b1; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (2) @(negedge Clock);
    check("abort_busy_before", Busy, 1'b1);
    Reset = 1'b1;
    @(negedge Clock);
    $display("abort: busy=%b done=%b out=%h flags=%b", Busy, Done, ALUOut, FlagsOut);
    check("abort_busy", Busy, 1'b0);
    check("abort_done", Done, 1'b0);
    check("abort_flags", FlagsOut, 4'b0000);
    check("abort_out", ALUOut, 16'h0000);
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      check("abort_no_done", Done, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
